mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of client channels; legal range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32: width of the client address and of mem_a.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port rdy, input, 1: global enable; when low, the block pauses.
REQ-006 SHALL have ports req, wr, done, each NUM_CH bits: req and wr are inputs, done is an output; one bit per channel for request, write-not-read, and completion pulse.
REQ-007 SHALL have inputs addr (NUM_CH*ADDR_W), size (NUM_CH*2) and wdata (NUM_CH*32): flattened per-channel fields, with channel i at slice i.
REQ-008 SHALL have output rdata, 32: read result shared by all channels.
REQ-009 SHALL have input flush, 1: pipeline rollback (misprediction or jump).
REQ-010 SHALL have mem_din input 8, mem_dout output 8, mem_a output ADDR_W, mem_wr output 1: byte-serial RAM port.
REQ-011 SHALL have input io_buffer_full, 1: UART TX buffer is full.

Function
REQ-012 SHALL use the size encoding 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes; 11 SHALL be treated as 4 bytes.
REQ-013 SHALL implement an FSM with states IDLE, READ and WRITE, plus a byte counter k.
REQ-014 In IDLE, when any req bit is high and flush is low, SHALL grant one channel round-robin, starting the search at (last_grant+1) mod NUM_CH.
REQ-015 On grant, SHALL latch addr, size, wr and wdata, and move to READ or WRITE with k=0.
REQ-016 In READ, for k<N SHALL drive mem_a=base+k and mem_wr=0.
REQ-017 In READ, at k≥1 SHALL capture mem_din into byte k-1 of rdata, little-endian.
REQ-018 In READ, at k=N SHALL go to IDLE.
REQ-019 In WRITE, for k<N SHALL drive mem_a=base+k, mem_dout=wdata byte k and mem_wr=1.
REQ-020 In WRITE, after k=N-1 SHALL go to IDLE.
REQ-021 SHALL pulse done[granted] for exactly one cycle, registered, in the cycle after the FSM returns to IDLE.
REQ-022 A grant seen at cycle T SHALL give done at T+N+2 for reads (4 bytes: T+6) and at T+N+1 for writes (4 bytes: T+5).
REQ-023 On reads, rdata SHALL be zero-extended above N bytes and held until the next read done.
REQ-024 Outside READ/WRITE bus cycles, mem_a SHALL be 0, mem_wr SHALL be 0 and mem_dout SHALL be 0.
REQ-025 When flush is high during READ, the block SHALL return to IDLE next cycle with no done pulse.
REQ-026 A WRITE in progress SHALL ignore flush and complete.
REQ-027 When flush is high in IDLE, the block SHALL suppress the grant for that cycle.
REQ-028 While rdy is low, all registers SHALL hold, mem_wr SHALL be forced to 0 and done SHALL be 0.
REQ-029 A client SHALL hold req and its fields stable until its done pulse; the block SHALL not re-grant the same request in the same cycle as its done pulse.
REQ-030 Only the granted channel SHALL receive done; simultaneous requests SHALL be served serially in round-robin order.

Reset
REQ-031 With rst low, the FSM SHALL go to IDLE immediately, asynchronously, regardless of clk and rdy.
REQ-032 Reset values SHALL be: k=0, last_grant=NUM_CH-1 (so channel 0 wins first), done=0, rdata=0, mem_a=0, mem_dout=0, mem_wr=0.
REQ-033 Reset during a transfer SHALL abandon the transfer without a done pulse.

Configuration
REQ-034 Macro MEM_IO_STALL_EN, when defined: a WRITE whose address has bits [17:16]=2'b11 SHALL wait at k=0 with mem_wr=0 while io_buffer_full is high.
REQ-035 Such a write SHALL proceed in the first cycle io_buffer_full is low, and done timing SHALL shift by the number of stall cycles.
REQ-036 With MEM_IO_STALL_EN undefined, io_buffer_full SHALL be ignored and timing SHALL follow REQ-022.

Structure
REQ-037 A shared package mem_pkg SHALL hold the size encoding constants, the FSM state typedef and the IO address-region constant (2'b11 in bits [17:16]).
REQ-038 A sub-module rr_arbiter, parameterised by NUM_CH, SHALL take the req vector and last_grant and return a one-hot grant and its index.

Verification
REQ-039 Bench SHALL cover: channel 0 reads 4 bytes at 0x100, with RAM bytes 11,22,33,44 → done[0] at T+6, rdata=0x44332211.
REQ-040 Bench SHALL cover: channel 1 writes 2 bytes 0xBEEF at 0x200 → mem_wr high for 2 cycles with mem_a 0x200 then 0x201 and mem_dout EF then BE; done[1] at T+3.
REQ-041 Bench SHALL cover: both channels request in the same cycle, twice in succession → order ch0, ch1, ch0, ch1, with no cycle where both done bits are high.
REQ-042 Bench SHALL cover: flush at k=2 of a 4-byte read → IDLE next cycle and no done; a 1-byte write with flush asserted still gives done.
REQ-043 Bench SHALL cover: with MEM_IO_STALL_EN, a 1-byte write to 0x30000 with io_buffer_full high for 3 cycles → mem_wr low for those 3 cycles, then one write pulse, done at T+5.
REQ-044 Bench SHALL cover: rst dropped mid-read → all outputs 0 asynchronously, and a later channel-0 request completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings, FSM state type and IO region constant for the memory port arbiter
package mem_pkg;

  localparam logic [1:0] SIZE_1B     = 2'b00;
  localparam logic [1:0] SIZE_2B     = 2'b01;
  localparam logic [1:0] SIZE_4B     = 2'b10;
  localparam logic [1:0] SIZE_4B_ALT = 2'b11;

  localparam logic [1:0] IO_REGION     = 2'b11;
  localparam int         IO_REGION_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_1B: return 3'd1;
      SIZE_2B: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker: first requester after the last grant, one-hot plus index
module rr_arbiter #(
  parameter  int NUM_CH = 2,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_last_grant,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IDX_W-1:0]  o_grant_idx,
  output logic              o_valid
);

  int w_ch;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_valid     = 1'b0;
    w_ch        = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_ch = (int'(i_last_grant) + i) % NUM_CH;
      if (!o_valid && i_req[w_ch]) begin
        o_valid           = 1'b1;
        o_grant[w_ch]     = 1'b1;
        o_grant_idx       = w_ch[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - multi-channel arbiter onto a byte-serial RAM port
// Optional MEM_IO_STALL_EN: writes into the IO region wait at byte 0 while io_buffer_full is high.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        wr,
  output logic [NUM_CH-1:0]        done,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*2-1:0]      size,
  input  logic [NUM_CH*32-1:0]     wdata,
  output logic [31:0]              rdata,
  input  logic                     flush,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              r_state, w_state_n;
  logic [2:0]          r_k, w_k_n, r_n;
  logic [IDX_W-1:0]    r_last, w_gidx;
  logic [NUM_CH-1:0]   w_grant, r_gnt, r_done;
  logic                w_gvalid, w_take, w_finish, w_stall;
  logic [ADDR_W-1:0]   r_base, w_sel_addr;
  logic [1:0]          w_sel_size, w_bsel;
  logic                w_sel_wr;
  logic [31:0]         w_sel_wdata, r_wdata, r_rbuf, w_rbuf_cap, r_rdata;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .i_req        (req),
    .i_last_grant (r_last),
    .o_grant      (w_grant),
    .o_grant_idx  (w_gidx),
    .o_valid      (w_gvalid)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_size  = '0;
    w_sel_wr    = 1'b0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(w_gidx) == i) begin
        w_sel_addr  = addr[i*ADDR_W +: ADDR_W];
        w_sel_size  = size[i*2 +: 2];
        w_sel_wr    = wr[i];
        w_sel_wdata = wdata[i*32 +: 32];
      end
    end
  end

`ifdef MEM_IO_STALL_EN
  assign w_stall = (r_state == ST_WRITE) && (r_k == 3'd0) &&
                   (r_base[IO_REGION_LSB +: 2] == IO_REGION) && io_buffer_full;
`else
  logic w_unused_io;
  assign w_stall     = 1'b0;
  assign w_unused_io = io_buffer_full;
`endif

  // No grant while done is showing, so a still-held request is not served twice.
  always_comb begin
    w_state_n = r_state;
    w_k_n     = r_k;
    w_take    = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gvalid && !flush && (r_done == '0)) begin
          w_take    = 1'b1;
          w_k_n     = 3'd0;
          w_state_n = w_sel_wr ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (flush) begin
          w_state_n = ST_IDLE;
          w_k_n     = 3'd0;
        end else if (r_k == r_n) begin
          w_state_n = ST_IDLE;
          w_k_n     = 3'd0;
          w_finish  = 1'b1;
        end else begin
          w_k_n = r_k + 3'd1;
        end
      end
      ST_WRITE: begin
        if (!w_stall) begin
          if (r_k == r_n - 3'd1) begin
            w_state_n = ST_IDLE;
            w_k_n     = 3'd0;
            w_finish  = 1'b1;
          end else begin
            w_k_n = r_k + 3'd1;
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (r_state == ST_READ && r_k < r_n) begin
      mem_a = r_base + ADDR_W'(r_k);
    end
    if (r_state == ST_WRITE && !w_stall) begin
      mem_a    = r_base + ADDR_W'(r_k);
      mem_dout = r_wdata[{r_k[1:0], 3'b000} +: 8];
      mem_wr   = rdy;
    end
  end

  // RAM data lags the address by one cycle, so cycle k carries byte k-1.
  assign w_bsel = r_k[1:0] - 2'd1;
  always_comb begin
    w_rbuf_cap = r_rbuf;
    w_rbuf_cap[{w_bsel, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_k     <= 3'd0;
      r_n     <= 3'd0;
      r_last  <= IDX_W'(NUM_CH - 1);
      r_gnt   <= '0;
      r_done  <= '0;
      r_base  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_rdata <= '0;
    end else if (rdy) begin
      r_state <= w_state_n;
      r_k     <= w_k_n;
      r_done  <= w_finish ? r_gnt : '0;
      if (w_take) begin
        r_last  <= w_gidx;
        r_gnt   <= w_grant;
        r_base  <= w_sel_addr;
        r_n     <= size_bytes(w_sel_size);
        r_wdata <= w_sel_wdata;
        r_rbuf  <= '0;
      end else if (r_state == ST_READ && !flush && r_k != 3'd0) begin
        r_rbuf <= w_rbuf_cap;
        if (r_k == r_n) r_rdata <= w_rbuf_cap;
      end
    end
  end

  assign done  = rdy ? r_done : '0;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     rdy;
  logic [NUM_CH-1:0]        req, wr, done;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*2-1:0]      size;
  logic [NUM_CH*32-1:0]     wdata;
  logic [31:0]              rdata;
  logic                     flush;
  logic [7:0]               mem_din = 8'h00;
  logic [7:0]               mem_dout;
  logic [ADDR_W-1:0]        mem_a;
  logic                     mem_wr;
  logic                     io_full;

  int n_checks = 0;
  int n_fail   = 0;
  int n_both   = 0;
  int lat;
  int order[$];
  logic [31:0] wa[$];
  logic [7:0]  wd[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .req            (req),
    .wr             (wr),
    .done           (done),
    .addr           (addr),
    .size           (size),
    .wdata          (wdata),
    .rdata          (rdata),
    .flush          (flush),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_din <= 8'h11 * (8'(mem_a[1:0]) + 8'd1);

  always @(negedge clk) begin
    if (mem_wr) begin
      wa.push_back(mem_a);
      wd.push_back(mem_dout);
    end
    if (done == 2'b11) n_both++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] d);
    wr[ch]              = w;
    addr[ch*ADDR_W +: ADDR_W] = a;
    size[ch*2 +: 2]     = s;
    wdata[ch*32 +: 32]  = d;
  endtask

  task automatic wait_done(input int ch, output int l);
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done[ch]) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; req = '0; wr = '0; addr = '0; size = '0;
    wdata = '0; flush = 1'b0; io_full = 1'b0;
    tick(); tick();
    check("rst_done", done, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_dout", mem_dout, 8'h00);
    #3 rst = 1'b1;
    tick();

    set_ch(0, 1'b0, 32'h100, 2'b10, 32'h0);
    req[0] = 1'b1;
    wait_done(0, lat);
    check("rd4_latency", lat, 6);
    check("rd4_rdata", rdata, 32'h44332211);
    check("rd4_done1_low", done[1], 1'b0);
    req[0] = 1'b0;
    tick();
    check("rd4_done_one_cycle", done, 2'b00);

    wa.delete(); wd.delete();
    set_ch(1, 1'b1, 32'h200, 2'b01, 32'h0000BEEF);
    req[1] = 1'b1;
    wait_done(1, lat);
    req[1] = 1'b0;
    check("wr2_latency", lat, 3);
    check("wr2_count", wa.size(), 2);
    if (wa.size() == 2) begin
      check("wr2_a0", wa[0], 32'h200);
      check("wr2_d0", wd[0], 8'hEF);
      check("wr2_a1", wa[1], 32'h201);
      check("wr2_d1", wd[1], 8'hBE);
    end
    check("wr2_rdata_held", rdata, 32'h44332211);
    tick();

    set_ch(0, 1'b0, 32'h102, 2'b00, 32'h0);
    set_ch(1, 1'b1, 32'h400, 2'b00, 32'h77);
    n_both = 0;
    req = 2'b11;
    for (int i = 0; i < 80 && order.size() < 4; i++) begin
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        if (done[c]) begin
          order.push_back(c);
          req[c] = 1'b0;
        end
      end
      if (order.size() == 2 && req == 2'b00) req = 2'b11;
    end
    req = 2'b00;
    check("rr_count", order.size(), 4);
    if (order.size() == 4) begin
      check("rr_order0", order[0], 0);
      check("rr_order1", order[1], 1);
      check("rr_order2", order[2], 0);
      check("rr_order3", order[3], 1);
    end
    check("rr_no_double_done", n_both, 0);
    check("rd1_zero_ext", rdata, 32'h00000033);
    tick();

    set_ch(0, 1'b0, 32'h104, 2'b10, 32'h0);
    req[0] = 1'b1;
    tick(); tick(); tick();
    check("flush_rd_k2_addr", mem_a, 32'h106);
    flush = 1'b1;
    req[0] = 1'b0;
    tick();
    flush = 1'b0;
    check("flush_rd_idle_addr", mem_a, 32'h0);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (done != 2'b00) lat = i;
    end
    check("flush_rd_no_done", lat, 0);
    check("flush_rd_rdata_held", rdata, 32'h00000033);

    wa.delete(); wd.delete();
    set_ch(0, 1'b1, 32'h108, 2'b00, 32'h5A);
    req[0] = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    check("flush_wr_done", done[0], 1'b1);
    req[0] = 1'b0;
    flush = 1'b0;
    check("flush_wr_count", wa.size(), 1);
    if (wa.size() == 1) begin
      check("flush_wr_a", wa[0], 32'h108);
      check("flush_wr_d", wd[0], 8'h5A);
    end
    tick();

    set_ch(0, 1'b1, 32'h500, 2'b00, 32'h3C);
    req[0] = 1'b1;
    tick();
    rdy = 1'b0;
    #1;
    check("rdy_low_wr", mem_wr, 1'b0);
    tick(); tick();
    check("rdy_low_wr_hold", mem_wr, 1'b0);
    check("rdy_low_done", done, 2'b00);
    rdy = 1'b1;
    #1;
    check("rdy_resume_wr", mem_wr, 1'b1);
    check("rdy_resume_a", mem_a, 32'h500);
    tick();
    check("rdy_resume_done", done[0], 1'b1);
    req[0] = 1'b0;
    tick();

    wa.delete(); wd.delete();
    set_ch(1, 1'b1, 32'h30000, 2'b00, 32'hA5);
    io_full = 1'b1;
    req[1] = 1'b1;
`ifdef MEM_IO_STALL_EN
    tick();
    check("stall_wr_c1", mem_wr, 1'b0);
    tick();
    check("stall_wr_c2", mem_wr, 1'b0);
    tick();
    check("stall_wr_c3", mem_wr, 1'b0);
    tick();
    io_full = 1'b0;
    #1;
    check("stall_wr_go", mem_wr, 1'b1);
    check("stall_wr_dout", mem_dout, 8'hA5);
    tick();
    check("stall_done_t5", done[1], 1'b1);
`else
    wait_done(1, lat);
    check("io_full_ignored_latency", lat, 2);
`endif
    req[1] = 1'b0;
    io_full = 1'b0;
    check("io_wr_count", wa.size(), 1);
    tick();

    set_ch(0, 1'b0, 32'h100, 2'b10, 32'h0);
    req[0] = 1'b1;
    tick(); tick();
    check("rstmid_addr_before", mem_a, 32'h101);
    #3 rst = 1'b0;
    #1;
    check("rstmid_mem_a", mem_a, 32'h0);
    check("rstmid_mem_wr", mem_wr, 1'b0);
    check("rstmid_mem_dout", mem_dout, 8'h00);
    check("rstmid_done", done, 2'b00);
    check("rstmid_rdata", rdata, 32'h0);
    req[0] = 1'b0;
    tick(); tick();
    check("rstmid_done_hold", done, 2'b00);
    #3 rst = 1'b1;
    tick();
    req[0] = 1'b1;
    wait_done(0, lat);
    req[0] = 1'b0;
    check("post_rst_latency", lat, 6);
    check("post_rst_rdata", rdata, 32'h44332211);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
